apb4_master: RTL and testbench
==============================

APB4_MASTER -- requirements
Module: apb4_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning the PADDR and request-address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-003 SHALL have ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
REQ-004 SHALL have request ports:
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  32  write data.
- req_wstrb_i  in  4  byte strobes.
- req_prot_i  in  3  protection attributes.
REQ-005 SHALL have response ports:
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_rdata_o  out  32  read data.
- rsp_err_o  out  1  error, from PSLVERR or timeout.
- rsp_tout_o  out  1  error caused by timeout.
REQ-006 SHALL have APB4 initiator ports:
- paddr_o  out  ADDR_WIDTH
- pprot_o  out  3
- psel_o  out  1
- penable_o  out  1
- pwrite_o  out  1
- pwdata_o  out  32
- pstrb_o  out  4
- pready_i  in  1
- prdata_i  in  32
- pslverr_i  in  1

Function
REQ-007 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, holding one outstanding transfer.
REQ-008 SHALL assert req_ready_o only in IDLE; on req_valid_i && req_ready_o it SHALL register write, address, wdata, strobe and prot, then enter SETUP.
REQ-009 In SETUP, SHALL drive psel_o=1 and penable_o=0 for exactly one cycle, then enter ACCESS.
REQ-010 In ACCESS, SHALL drive psel_o=1 and penable_o=1 until pready_i=1 or timeout.
REQ-011 SHALL hold paddr_o, pprot_o, pwrite_o, pwdata_o and pstrb_o stable from SETUP through the last ACCESS cycle, driven from the registered request.
REQ-012 SHALL drive pstrb_o=0 for reads.
REQ-013 SHALL drive pwdata_o=0 for reads.
REQ-014 On ACCESS with pready_i=1, SHALL capture the response and enter RESP, deasserting psel_o and penable_o the next cycle:
- rsp_rdata_o = prdata_i for reads, 0 for writes;
- rsp_err_o = pslverr_i;
- rsp_tout_o = 0.
REQ-015 SHALL count ACCESS cycles with a wait counter cleared on entering ACCESS.
REQ-016 If TIMEOUT>0 and the TIMEOUT-th ACCESS cycle sees pready_i=0, SHALL abort and enter RESP with rsp_err_o=1, rsp_tout_o=1, rsp_rdata_o=0.
REQ-017 If pready_i=1 on the TIMEOUT-th ACCESS cycle, SHALL treat the transfer as normally completed, not timed out.
REQ-018 SHALL hold rsp_valid_o=1 with stable response fields in RESP until rsp_ready_i=1, then enter IDLE.
REQ-019 SHALL ignore pready_i, prdata_i and pslverr_i outside ACCESS.
REQ-020 SHALL ignore request inputs outside IDLE.
REQ-021 Minimum transfer time SHALL be 4 cycles: accept, SETUP, ACCESS, RESP with rsp_ready_i=1.
REQ-022 Each added ACCESS wait cycle SHALL add exactly one cycle.
REQ-023 SHALL drive psel_o and penable_o from registers, with no combinational path from pready_i to any APB output.

Reset
REQ-024 While rst_i=1, SHALL force IDLE and drive 0 on every output, including req_ready_o.
REQ-025 req_ready_o SHALL become 1 on the first clock edge after rst_i deasserts.
REQ-026 rst_i asserted mid-transfer (SETUP, ACCESS or RESP) SHALL immediately drop psel_o, penable_o and rsp_valid_o to 0 and discard the transfer, with no response issued.

Verification
REQ-027 Single write: addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, pready_i tied 1 -> SETUP then one ACCESS cycle with paddr_o=0x10 and pstrb_o=0xF; rsp_valid_o two cycles after accept with rsp_err_o=0.
REQ-028 Read with 3 wait states, prdata_i=0x12345678 -> penable_o high for 4 cycles; rsp_rdata_o=0x12345678; pstrb_o=0 throughout.
REQ-029 Timeout, TIMEOUT=4, pready_i held 0 -> penable_o high exactly 4 cycles; rsp_err_o=1, rsp_tout_o=1, rsp_rdata_o=0.
REQ-030 Slave error: pslverr_i=1 with pready_i=1 -> rsp_err_o=1, rsp_tout_o=0.
REQ-031 Response backpressure: rsp_ready_i low 5 cycles -> rsp_valid_o and fields stable, req_ready_o=0, no APB activity; req_ready_o=1 the cycle after rsp_ready_i=1.
REQ-032 Reset in ACCESS -> psel_o and penable_o 0 asynchronously; after release, req_ready_o=1 and no stale response.

Source files
------------

// File: rtl/apb4_master.sv
// APB4 initiator: takes one request at a time over a valid/ready port, runs the
// SETUP/ACCESS phases with an optional wait-state timeout and holds the response until consumed.
module apb4_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // Handshakes: a beat moves on a rising edge where valid && ready; valid holds its
   // payload until that edge, and ready may depend only on registered state.
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   input  logic [3:0]            req_wstrb_i,
   input  logic [2:0]            req_prot_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_tout_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [2:0]            pprot_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [31:0]           pwdata_o,
   output logic [3:0]            pstrb_o,
   input  logic                  pready_i,
   input  logic [31:0]           prdata_i,
   input  logic                  pslverr_i,
   output logic [1:0]            state_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

   state_t          state;
   state_t          state_nxt;
   logic            ready_q;
   logic            accept;
   logic            last_wait;
   logic [CW-1:0]   wait_cnt;

   // last_wait marks the TIMEOUT-th ACCESS cycle; never true when the timeout is disabled.
   assign last_wait = (TIMEOUT > 0) && (wait_cnt == CW'(TIMEOUT - 1));
   assign accept    = (state == IDLE) && req_valid_i && ready_q;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (pready_i || last_wait) state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ready is registered so it stays low while reset is held and rises one edge later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt == IDLE);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         paddr_o  <= '0;
         pprot_o  <= '0;
         pwrite_o <= 1'b0;
         pwdata_o <= '0;
         pstrb_o  <= '0;
      end else if (accept) begin
         paddr_o  <= req_addr_i;
         pprot_o  <= req_prot_i;
         pwrite_o <= req_write_i;
         pwdata_o <= req_write_i ? req_wdata_i : 32'd0;
         pstrb_o  <= req_write_i ? req_wstrb_i : 4'd0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wait_cnt <= '0;
      end else if (state == SETUP) begin
         wait_cnt <= '0;
      end else if (state == ACCESS && !last_wait) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // A completing pready wins over the timeout on the same cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         rsp_tout_o  <= 1'b0;
      end else if (state == ACCESS) begin
         if (pready_i) begin
            rsp_rdata_o <= pwrite_o ? 32'd0 : prdata_i;
            rsp_err_o   <= pslverr_i;
            rsp_tout_o  <= 1'b0;
         end else if (last_wait) begin
            rsp_rdata_o <= 32'd0;
            rsp_err_o   <= 1'b1;
            rsp_tout_o  <= 1'b1;
         end
      end
   end

   assign req_ready_o = ready_q;
   assign psel_o      = (state == SETUP) || (state == ACCESS);
   assign penable_o   = (state == ACCESS);
   assign rsp_valid_o = (state == RESP);
   assign state_o     = state;

endmodule

// File: tb/tb_apb4_master.sv
// Bench for apb4_master: a vector table of transfers driven against a small APB slave
// model, responses checked from an expected queue, plus reset-in-flight sequences.
module tb_apb4_master;

   localparam int AW  = 32;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic [3:0]    req_wstrb = '0;
   logic [2:0]    req_prot = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          rsp_tout;
   logic [AW-1:0] paddr;
   logic [2:0]    pprot;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [31:0]   pwdata;
   logic [3:0]    pstrb;
   logic          pready = 1'b0;
   logic [31:0]   prdata = '0;
   logic          pslverr = 1'b0;
   logic [1:0]    state;

   apb4_master #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .req_prot_i(req_prot),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
      .rsp_err_o(rsp_err), .rsp_tout_o(rsp_tout),
      .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
      .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
      .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr),
      .state_o(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          rsp_delay;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_tout;
      int          exp_pen;
   } vec_t;

   vec_t        vecs[8];
   logic [33:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_txn(input vec_t v);
      logic [31:0] e_wdata;
      logic [3:0]  e_strb;
      logic [33:0] e;
      int          acc;
      bit          done;
      e_wdata = v.wr ? v.wdata : 32'd0;
      e_strb  = v.wr ? v.wstrb : 4'd0;
      @(negedge clk);
      chk("idle_req_ready", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_wstrb = v.wstrb;
      req_prot  = v.prot;
      pready    = 1'($urandom_range(0, 1));
      exp_q.push_back({v.exp_rdata, v.exp_err, v.exp_tout});
      @(negedge clk);
      // Request inputs scrambled from here on: the master must ignore them outside IDLE.
      req_valid = 1'($urandom_range(0, 1));
      req_write = ~v.wr;
      req_addr  = $urandom;
      req_wdata = $urandom;
      req_wstrb = 4'($urandom_range(0, 15));
      req_prot  = 3'($urandom_range(0, 7));
      chk("setup_psel", 64'(psel), 64'd1);
      chk("setup_penable", 64'(penable), 64'd0);
      chk("setup_req_ready", 64'(req_ready), 64'd0);
      chk("setup_paddr", 64'(paddr), 64'(v.addr));
      chk("setup_pwrite", 64'(pwrite), 64'(v.wr));
      chk("setup_pwdata", 64'(pwdata), 64'(e_wdata));
      chk("setup_pstrb", 64'(pstrb), 64'(e_strb));
      chk("setup_pprot", 64'(pprot), 64'(v.prot));
      pready  = 1'b1;
      pslverr = 1'b1;
      prdata  = $urandom;
      acc  = 0;
      done = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if (!(psel && penable)) begin
            done = 1'b1;
         end else begin
            acc++;
            chk("access_paddr", 64'(paddr), 64'(v.addr));
            chk("access_pstrb", 64'(pstrb), 64'(e_strb));
            chk("access_pwdata", 64'(pwdata), 64'(e_wdata));
            pready  = (acc == v.waits + 1);
            prdata  = pready ? v.prdata : $urandom;
            pslverr = pready ? v.slverr : 1'b1;
         end
      end
      if (!done) chk("access_bound", 64'd1, 64'd0);
      chk("penable_cycles", 64'(acc), 64'(v.exp_pen));
      req_valid = 1'b0;
      for (int d = 0; d <= v.rsp_delay; d++) begin
         if (d > 0) @(negedge clk);
         pready  = 1'($urandom_range(0, 1));
         prdata  = $urandom;
         pslverr = 1'($urandom_range(0, 1));
         chk("resp_valid", 64'(rsp_valid), 64'd1);
         chk("resp_psel", 64'(psel), 64'd0);
         chk("resp_penable", 64'(penable), 64'd0);
         chk("resp_req_ready", 64'(req_ready), 64'd0);
         if (exp_q.size() == 0) begin
            chk("resp_queue_empty", 64'd1, 64'd0);
         end else begin
            e = exp_q[0];
            chk("rsp_rdata", 64'(rsp_rdata), 64'(e[33:2]));
            chk("rsp_err", 64'(rsp_err), 64'(e[1]));
            chk("rsp_tout", 64'(rsp_tout), 64'(e[0]));
         end
         rsp_ready = (d == v.rsp_delay);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("post_req_ready", 64'(req_ready), 64'd1);
      chk("post_psel", 64'(psel), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          wr    addr          wdata         strb  prot  w  prdata        err  dly  exp_rdata     e_err e_to pen
      vecs[0] = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0,        1'b0, 0, 32'h0,        1'b0, 1'b0, 1};
      vecs[1] = '{1'b0, 32'h20,       32'h0,        4'h0, 3'd0, 3, 32'h12345678, 1'b0, 1, 32'h12345678, 1'b0, 1'b0, 4};
      vecs[2] = '{1'b0, 32'h30,       32'h0,        4'hF, 3'd2, 4, 32'hCAFEF00D, 1'b0, 0, 32'h0,        1'b1, 1'b1, 4};
      vecs[3] = '{1'b1, 32'h44,       32'h11223344, 4'h3, 3'd2, 0, 32'h99999999, 1'b1, 0, 32'h0,        1'b1, 1'b0, 1};
      vecs[4] = '{1'b0, 32'h50,       32'h0,        4'hF, 3'd1, 1, 32'h0BADF00D, 1'b1, 5, 32'h0BADF00D, 1'b1, 1'b0, 2};
      vecs[5] = '{1'b1, 32'h1000,     32'h55AA55AA, 4'h5, 3'd5, 2, 32'h0,        1'b0, 2, 32'h0,        1'b0, 1'b0, 3};
      vecs[6] = '{1'b1, 32'h2000,     32'h0F0F0F0F, 4'hF, 3'd1, 6, 32'h0,        1'b0, 0, 32'h0,        1'b1, 1'b1, 4};
      vecs[7] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'hA, 3'd7, 0, 32'hA5A5A5A5, 1'b0, 0, 32'hA5A5A5A5, 1'b0, 1'b0, 1};

      // Reset state, then the first edge after release raises ready.
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_psel", 64'(psel), 64'd0);
      chk("rst_penable", 64'(penable), 64'd0);
      chk("rst_pwrite", 64'(pwrite), 64'd0);
      chk("rst_paddr", 64'(paddr), 64'd0);
      chk("rst_pwdata", 64'(pwdata), 64'd0);
      chk("rst_pstrb", 64'(pstrb), 64'd0);
      chk("rst_pprot", 64'(pprot), 64'd0);
      chk("rst_rsp_fields", 64'({rsp_rdata, rsp_err, rsp_tout}), 64'd0);
      chk("rst_state", 64'(state), 64'd0);
      rst = 1'b0;
      #1;
      chk("release_req_ready_before_edge", 64'(req_ready), 64'd0);
      @(negedge clk);
      chk("release_req_ready_after_edge", 64'(req_ready), 64'd1);

      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // Reset while waiting in ACCESS: APB strobes drop at once and nothing is answered.
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h77;
      @(negedge clk);
      req_valid = 1'b0;
      pready    = 1'b0;
      repeat (2) @(negedge clk);
      chk("pre_rst_penable", 64'(penable), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_psel", 64'(psel), 64'd0);
      chk("mid_rst_penable", 64'(penable), 64'd0);
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_req_ready", 64'(req_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         pready = 1'b1;
         @(negedge clk);
         chk("after_rst_no_stale_rsp", 64'(rsp_valid), 64'd0);
         chk("after_rst_no_apb", 64'(psel), 64'd0);
      end
      pready = 1'b0;

      // Reset during SETUP, then a clean transfer must still work.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h88;
      @(negedge clk);
      req_valid = 1'b0;
      chk("setup_before_rst", 64'(psel), 64'd1);
      rst = 1'b1;
      #1;
      chk("setup_rst_psel", 64'(psel), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_txn(vecs[0]);
      run_txn(vecs[1]);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
